// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port byte-addressed data memory between the CPU
// load/store path (port 0) and a DMA/debug requester (port 1). Each accepted request
// is registered, drives the memory for exactly one cycle, and answers with a one-cycle
// response pulse two cycles after the handshake. Misaligned or out-of-range accesses
// are answered with rsp_err and never reach the memory.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties,
// port 1 can starve); otherwise ties alternate round-robin.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 131072
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    output logic                  mem_addr_mode,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    // Highest legal start address for each access size.
    localparam logic [ADDR_WIDTH-1:0] MaxByteAddr = ADDR_WIDTH'(MEM_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] MaxWordAddr = ADDR_WIDTH'(MEM_BYTES - 4);

    state_e                state_q, state_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic                  byte_q, byte_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                  last_q, last_d;
`endif

    logic                  win;
    logic                  hs;
    logic                  sel_byte;
    logic                  sel_err;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Arbitration: pick the winner and raise req_ready for it only, in IDLE.
    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win = ~req_valid[0];
`else
        // On a tie the port that did not win last time goes first.
        win = (&req_valid) ? ~last_q : ~req_valid[0];
`endif
        hs        = (state_q == StIdle) && (|req_valid);
        req_ready = 2'b00;
        if (hs) begin
            req_ready[win] = 1'b1;
        end
    end

    // Mux the winning port's fields and classify the access before capture.
    always_comb begin
        sel_addr  = win ? req_addr1 : req_addr0;
        sel_wdata = win ? req_wdata1 : req_wdata0;
        sel_byte  = req_byte[win];
        if (sel_byte) begin
            sel_err = (sel_addr > MaxByteAddr);
        end else begin
            sel_err = (sel_addr[1:0] != 2'b00) || (sel_addr > MaxWordAddr);
        end
    end

    // Sequencer next state: capture on handshake, access one cycle, respond one cycle.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        byte_d  = byte_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    state_d = StAccess;
                    port_d  = win;
                    we_d    = req_we[win];
                    byte_d  = sel_byte;
                    err_d   = sel_err;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    // Writes and rejected accesses answer with zero data.
                    rdata_d = '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            StAccess: begin
                if (!we_q && !err_q) begin
                    rdata_d = mem_RD;
                end
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and request/response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs decoded from state and the request/response registers.
    always_comb begin
        mem_A         = addr_q;
        mem_WD        = wdata_q;
        mem_addr_mode = byte_q;
        // rst_n gates the strobe so a reset on the access cycle never writes.
        mem_WE        = (state_q == StAccess) && we_q && !err_q && rst_n;
        rsp_valid     = 2'b00;
        rsp_err       = 1'b0;
        if (state_q == StResp) begin
            rsp_valid[port_q] = 1'b1;
            rsp_err           = err_q;
        end
        rsp_rdata     = rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned MB = 131072;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit Fixed = 1'b1;
`else
    localparam bit Fixed = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_we, req_byte, rsp_valid;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic        rsp_err, mem_WE, mem_addr_mode;
    logic [31:0] rsp_rdata, mem_A, mem_WD, mem_RD;

    dmem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_byte      (req_byte),
        .req_addr0     (req_addr0),
        .req_addr1     (req_addr1),
        .req_wdata0    (req_wdata0),
        .req_wdata1    (req_wdata1),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .mem_A         (mem_A),
        .mem_WD        (mem_WD),
        .mem_WE        (mem_WE),
        .mem_addr_mode (mem_addr_mode),
        .mem_RD        (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory attached to the DUT (sparse; unwritten bytes read as zero).
    logic [7:0] dmem [logic [31:0]];
    // Reference memory image kept by the model.
    logic [7:0] rmem [logic [31:0]];

    function automatic logic [7:0] drd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 8'h00;
    endfunction
    function automatic logic [7:0] rrd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_WE) begin
            if (mem_addr_mode) begin
                if (mem_A < MB) dmem[mem_A] = mem_WD[7:0];
            end else if (mem_A <= MB - 4) begin
                for (int i = 0; i < 4; i++) dmem[mem_A + 32'(i)] = mem_WD[8*i +: 8];
            end
        end
    end

    // Read data settles mid-cycle from the current address; byte reads zero-extended.
    always @(negedge clk) begin
        if (mem_addr_mode) begin
            mem_RD <= (mem_A < MB) ? {24'h0, drd(mem_A)} : 32'h0;
        end else begin
            mem_RD <= (mem_A <= MB - 4) ?
                {drd(mem_A + 3), drd(mem_A + 2), drd(mem_A + 1), drd(mem_A)} : 32'h0;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic bad_access(input logic bm, input logic [31:0] a);
        if (bm) return a > MB - 1;
        return (a % 4 != 0) || (a > MB - 4);
    endfunction

    function automatic logic [31:0] ref_read(input logic bm, input logic [31:0] a);
        if (bm) return {24'h0, rrd(a)};
        return {rrd(a + 3), rrd(a + 2), rrd(a + 1), rrd(a)};
    endfunction

    task automatic ref_write(input logic bm, input logic [31:0] a, input logic [31:0] d);
        if (bm) rmem[a] = d[7:0];
        else for (int i = 0; i < 4; i++) rmem[a + 32'(i)] = d[8*i +: 8];
    endtask

    logic        mon_en = 1'b0;
    logic        rst_seen = 1'b1;
    int          since = -1;      // cycles since the accepted request; -1 when free
    int          cyc = 0;
    logic        m_last = 1'b1;
    logic        m_port, m_we, m_bm, m_err, win;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  exp_ready;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                check("reset ctrl {rsp_valid,rsp_err,mem_WE,mode}",
                      {rsp_valid, rsp_err, mem_WE, mem_addr_mode}, 5'b0);
                check("reset rsp_rdata", rsp_rdata, 32'h0);
                check("reset mem_A", mem_A, 32'h0);
                check("reset mem_WD", mem_WD, 32'h0);
                rst_seen = 1'b0;
            end
            exp_ready = 2'b00;
            win = 1'b0;
            if (since < 0 && req_valid != 2'b00) begin
                if (&req_valid) win = Fixed ? 1'b0 : ~m_last;
                else            win = req_valid[1];
                exp_ready[win] = 1'b1;
            end
            check("req_ready", req_ready, exp_ready);
            check("mem_WE", mem_WE, (since == 1) && m_we && !m_err && rst_n);
            if (since == 1) begin
                check("mem_A", mem_A, m_addr);
                check("mem_addr_mode", mem_addr_mode, m_bm);
                check("mem_WD", mem_WD, m_wdata);
            end
            check("rsp_valid", rsp_valid, (since == 2) ? (m_port ? 2'b10 : 2'b01) : 2'b00);
            if (since == 2) begin
                check("rsp_err", rsp_err, m_err);
                check("rsp_rdata", rsp_rdata, (m_err || m_we) ? 32'h0 : ref_read(m_bm, m_addr));
            end
            // Predict the effect of the coming rising edge.
            if (!rst_n) begin
                since    = -1;
                m_last   = 1'b1;
                rst_seen = 1'b1;
            end else if (since == 1) begin
                if (m_we && !m_err) ref_write(m_bm, m_addr, m_wdata);
                since = 2;
            end else if (since == 2) begin
                since = -1;
            end else if (exp_ready != 2'b00) begin
                m_port  = win;
                m_we    = req_we[win];
                m_bm    = req_byte[win];
                m_addr  = win ? req_addr1 : req_addr0;
                m_wdata = win ? req_wdata1 : req_wdata0;
                m_err   = bad_access(m_bm, m_addr);
                m_last  = win;
                since   = 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic        port;
        logic        we;
        logic        bm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic set_port(input logic p, input logic we, input logic bm,
                            input logic [31:0] a, input logic [31:0] wd);
        req_we[p]   = we;
        req_byte[p] = bm;
        if (p) begin
            req_addr1  = a;
            req_wdata1 = wd;
        end else begin
            req_addr0  = a;
            req_wdata0 = wd;
        end
    endtask

    // Issue one request from drive time; returns at drive time after completion.
    task automatic issue(input int idx, input vec_t v);
        logic got;
        int   lat;
        int   wes;
        set_port(v.port, v.we, v.bm, v.addr, v.wdata);
        req_valid[v.port] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[v.port]) got = 1'b1;
        end
        check($sformatf("vec%0d handshake", idx), got, 1'b1);
        @(posedge clk);
        #1;
        req_valid[v.port] = 1'b0;
        lat = 0;
        wes = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (mem_WE) wes++;
            if (rsp_valid[v.port] && lat == 0) begin
                lat = i;
                check($sformatf("vec%0d rsp_err", idx), rsp_err, v.err);
                check($sformatf("vec%0d rsp_rdata", idx), rsp_rdata, v.rdata);
            end
        end
        check($sformatf("vec%0d latency", idx), lat, 2);
        check($sformatf("vec%0d mem_WE cycles", idx), wes, (v.we && !v.err) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        logic [1:0]  g;
        logic [5:0]  grants;
        int          n;
        int          hs_cyc [3];
        int          rsp_cnt, run, max_run, mism;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0101, 32'h0,         1'b0, 32'h0000_00BE};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h1111_1111, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0001_FFFD, 32'h0,         1'b1, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h0001_FFFF, 32'h0000_005A, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h0001_FFFF, 32'h0,         1'b0, 32'h0000_005A};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0001_FFFC, 32'h0,         1'b0, 32'h5A00_0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0002_0000, 32'h0,         1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0001_FFF8, 32'h1234_5678, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0001_FFF8, 32'h0,         1'b0, 32'h1234_5678};

        rst_n = 1'b0;
        req_valid = 2'b00;
        req_we = 2'b00;
        req_byte = 2'b00;
        req_addr0 = '0;
        req_addr1 = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Contention straight after reset: both ports hold valid for 6 grants.
        set_port(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        req_valid = 2'b11;
        n = 0;
        grants = '0;
        for (int t = 0; t < 40 && n < 6; t++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                grants[n] = req_ready[1];
                n++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("contention grant count", n, 6);
        check("contention grant order", grants, Fixed ? 6'b000000 : 6'b101010);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) issue(i, vecs[i]);
        check("word at 0x100 after error writes",
              {drd(32'h103), drd(32'h102), drd(32'h101), drd(32'h100)}, 32'hDEAD_BEEF);

        // Reset asserted during the access cycle of a write to 0x200.
        set_port(1'b0, 1'b1, 1'b0, 32'h200, 32'hCAFE_F00D);
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        check("reset-write handshake", got, 1'b1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset-write mem_WE", mem_WE, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset-write rsp_valid", rsp_valid, 2'b00);
        check("reset-write mem_A", mem_A, 32'h0);
        check("reset-write ready", req_ready, 2'b00);
        repeat (2) @(negedge clk);
        check("reset-write rsp_valid later", rsp_valid, 2'b00);
        check("word at 0x200 after reset",
              {drd(32'h203), drd(32'h202), drd(32'h201), drd(32'h200)}, 32'h0);
        @(posedge clk);
        #1;

        // Back-to-back: port 0 holds valid across 3 reads.
        set_port(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        req_valid[0] = 1'b1;
        n = 0;
        rsp_cnt = 0;
        run = 0;
        max_run = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                rsp_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (req_ready[0] && n < 3) begin
                hs_cyc[n] = cyc;
                n++;
                if (n == 3) begin
                    @(posedge clk);
                    #1;
                    req_valid[0] = 1'b0;
                end
            end
        end
        check("b2b handshake count", n, 3);
        check("b2b spacing 1-2", hs_cyc[1] - hs_cyc[0], 3);
        check("b2b spacing 2-3", hs_cyc[2] - hs_cyc[1], 3);
        check("b2b response count", rsp_cnt, 3);
        check("b2b response width", max_run, 1);
        @(posedge clk);
        #1;

        // Randomized traffic; requesters hold fields until accepted.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (!(req_valid[p] && !g[p])) begin
                    logic        bm;
                    logic [31:0] a;
                    int unsigned r;
                    bm = 1'($urandom_range(0, 1));
                    r  = $urandom_range(0, 7);
                    if (r < 6) begin
                        a = 32'h100 + 32'($urandom_range(0, 63));
                        if (!bm && r < 5) a = a & ~32'h3;
                    end else if (r == 6) begin
                        a = MB - 8 + 32'($urandom_range(0, 11));
                    end else begin
                        a = $urandom;
                    end
                    set_port(1'(p), 1'($urandom_range(0, 1)), bm, a, $urandom);
                    req_valid[p] = ($urandom_range(0, 2) != 0);
                end
            end
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        mism = 0;
        foreach (rmem[k]) if (drd(k) !== rmem[k]) mism++;
        foreach (dmem[k]) if (rrd(k) !== dmem[k]) mism++;
        check("memory image vs model", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port byte-addressed data memory. Shares the memory between the CPU load/store path (port 0) and a DMA/debug requester (port 1) using valid/ready request and valid-only response channels. Registers each accepted request, drives the memory for exactly one access cycle, and returns read data with a fixed latency. Rejects misaligned or out-of-range accesses with an error response and no memory access.

## Interface
- `ADDR_WIDTH`, 32: request and memory address width.
- `DATA_WIDTH`, 32: data width.
- `MEM_BYTES`, 131072: memory size in bytes. Valid accesses end at or below `MEM_BYTES-1`.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid[1:0]` in 2: per-port request valid.
- `req_ready[1:0]` out 2: per-port request accepted this cycle.
- `req_we[1:0]` in 2: per-port write (1) or read (0).
- `req_byte[1:0]` in 2: per-port byte mode (1) or word mode (0).
- `req_addr0`, `req_addr1` in ADDR_WIDTH: per-port byte address.
- `req_wdata0`, `req_wdata1` in DATA_WIDTH: per-port write data.
- `rsp_valid[1:0]` out 2: one-cycle response pulse on the owning port.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 means the access was rejected.
- `rsp_rdata` out DATA_WIDTH: read data. Zero for writes and for errors.
- `mem_A` out ADDR_WIDTH: memory address.
- `mem_WD` out DATA_WIDTH: memory write data.
- `mem_WE` out 1: memory write enable.
- `mem_addr_mode` out 1: memory byte mode.
- `mem_RD` in DATA_WIDTH: combinational memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `req_valid` is set, pick a winner and assert `req_ready` for the winner only. At most one `req_ready` bit is high per cycle.
  - On the handshake edge, capture port id, we, byte, addr and wdata into a request register, then go to ACCESS.
- **Arbitration**
  - Round-robin using a 1-bit `last` pointer.
  - When both ports request, the port != `last` wins.
  - When one port requests, it wins.
  - `last` updates to the winner on every handshake.
- **Checks at capture**
  - Error if word mode and `addr[1:0] != 0`.
  - Error if `addr > MEM_BYTES-1` (byte mode) or `addr > MEM_BYTES-4` (word mode).
  - The result is stored as `err_q`.
- **ACCESS**
  - `mem_A`, `mem_WD` and `mem_addr_mode` come from the request register.
  - `mem_WE = we_q & ~err_q & rst_n`.
  - If read and not error, capture `mem_RD` into the response register. Byte reads arrive zero-extended from the memory.
  - Go to RESP.
- **RESP**
  - Assert `rsp_valid[port_q]` and set `rsp_err = err_q`.
  - `rsp_rdata` is held from the capture.
  - Go to IDLE.
  - `req_ready` stays 0 in ACCESS and RESP.
- **Idle outputs**: when not in ACCESS, `mem_WE = 0`; `mem_A`, `mem_WD` and `mem_addr_mode` hold their last values.
- **Reset values**
  - State IDLE; `last = 1`, so port 0 wins the first tie.
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_err = 0`, `rsp_rdata = 0`.
  - `mem_WE = 0`, `mem_A = 0`, `mem_WD = 0`, `mem_addr_mode = 0`.
- **Reset mid-operation**: an in-flight request is dropped. No write occurs on the reset edge, and no response is issued.
- **Requester rules**
  - Requesters hold request fields stable while `req_valid` is high and `req_ready` is low.
  - The arbiter does not depend on `req_valid` outside IDLE.

## Timing
- Handshake at edge N.
- Memory access and, for writes, the memory write occur on edge N+1.
- `rsp_valid` is high for the cycle between edges N+1 and N+2.
- Next handshake is possible at edge N+3.
- Throughput: one access per 3 cycles.
- Latency from handshake to response visible: 2 cycles.
- `req_ready` is combinational from state, `req_valid` and `last`.
- All other outputs are registered or decoded from state only.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; port 0 always wins ties.
  - The `last` pointer is not implemented.
  - Port 1 can starve.
- `DMEM_ARB_FIXED_PRIO_EN` undefined: round-robin as described.

## Test plan
- **Single word write/read**
  - Stimulus: port 0 writes 0xDEADBEEF to 0x100, then reads 0x100.
  - Required: `mem_WE` is high for exactly one cycle; the read response is `rsp_valid[0]`, `rsp_err = 0`, `rsp_rdata = 0xDEADBEEF`, 2 cycles after the handshake.
- **Byte read**
  - Stimulus: port 1 reads 0x101 in byte mode after the word above.
  - Required: `rsp_rdata = 0x000000BE` on `rsp_valid[1]`.
- **Contention**
  - Stimulus: both ports hold `req_valid` continuously for 6 grants after reset.
  - Required, round-robin: grants go 0,1,0,1,0,1.
  - Required, with `DMEM_ARB_FIXED_PRIO_EN`: all 6 grants go to port 0.
- **Error paths**
  - Stimulus: word write to 0x102; word read at 0x1FFFD.
  - Required: `rsp_err = 1`, `rsp_rdata = 0`, `mem_WE` never asserts, and memory at 0x100 is unchanged.
- **Reset during write**
  - Stimulus: `rst_n` low on the ACCESS cycle of a write to 0x200.
  - Required: memory at 0x200 is unchanged, no `rsp_valid`, and all outputs show reset values on the next cycle.
- **Back-to-back**
  - Stimulus: port 0 holds valid across 3 reads.
  - Required: handshakes exactly 3 cycles apart; each `rsp_valid` is exactly 1 cycle wide.
